// File: rtl/aui_test_sequencer.sv
// Run-control FSM for the AUI generator/checker loopback: datapath reset, sync wait, error-counting window, verdict.
// Latency: every output is registered and follows the deciding edge by one cycle. No backpressure; i_start is a pulse, i_abort wins.
module aui_test_sequencer #(
  parameter int NUMBER_LANES  = 16,
  parameter int DP_RST_CYCLES = 8,
  parameter int SYNC_STABLE   = 32,
  parameter int SYNC_TIMEOUT  = 4096,
  parameter int RUN_CYCLES    = 65536,
  parameter int ERR_WIDTH     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [NUMBER_LANES-1:0] i_sync_lane,
  input  logic [NUMBER_LANES-1:0] i_lane_err,
  output logic                    o_dp_rst,
  output logic                    o_gen_en,
  output logic                    o_chk_en,
  output logic [2:0]              o_state,
  output logic                    o_done,
  output logic [1:0]              o_fail_code,
  output logic [ERR_WIDTH-1:0]    o_err_total,
  output logic [NUMBER_LANES-1:0] o_lane_mask
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DP_RESET  = 3'd1,
    S_WAIT_SYNC = 3'd2,
    S_RUN       = 3'd3,
    S_PASS      = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  localparam int DPW  = $clog2(DP_RST_CYCLES + 1);
  localparam int STW  = $clog2(SYNC_STABLE + 1);
  localparam int TOW  = $clog2(SYNC_TIMEOUT + 1);
  localparam int RNW  = $clog2(RUN_CYCLES + 1);
  localparam int POPW = $clog2(NUMBER_LANES + 1);
  localparam int SUMW = ERR_WIDTH + POPW;

  state_t            state;
  logic [DPW-1:0]    dp_cnt;
  logic [STW-1:0]    stable_cnt;
  logic [TOW-1:0]    timeout_cnt;
  logic [RNW-1:0]    run_cnt;

  logic              all_sync;
  logic [STW-1:0]    stable_inc;
  logic [TOW-1:0]    timeout_inc;
  logic [RNW-1:0]    run_inc;
  logic [POPW-1:0]   err_pop;
  logic [SUMW-1:0]   err_sum;
  logic [ERR_WIDTH-1:0] err_sat;

  assign o_state = state;

  always_comb begin
    all_sync    = &i_sync_lane;
    stable_inc  = stable_cnt + STW'(1);
    timeout_inc = timeout_cnt + TOW'(1);
    run_inc     = run_cnt + RNW'(1);
    err_pop     = '0;
    for (int i = 0; i < NUMBER_LANES; i++) begin
      err_pop = err_pop + POPW'(i_lane_err[i]);
    end
    // Sum is one popcount wider than the accumulator so overflow is visible before clamping.
    err_sum = SUMW'(o_err_total) + SUMW'(err_pop);
    err_sat = (err_sum > SUMW'({ERR_WIDTH{1'b1}})) ? {ERR_WIDTH{1'b1}} : err_sum[ERR_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || i_abort) begin
      state       <= S_IDLE;
      dp_cnt      <= '0;
      stable_cnt  <= '0;
      timeout_cnt <= '0;
      run_cnt     <= '0;
      o_dp_rst    <= 1'b1;
      o_gen_en    <= 1'b0;
      o_chk_en    <= 1'b0;
      o_done      <= 1'b0;
      o_fail_code <= '0;
      o_err_total <= '0;
      o_lane_mask <= '0;
    end else begin
      case (state)
        S_IDLE, S_PASS, S_FAIL: begin
          if (i_start) begin
            state       <= S_DP_RESET;
            dp_cnt      <= '0;
            o_dp_rst    <= 1'b1;
            o_gen_en    <= 1'b0;
            o_chk_en    <= 1'b0;
            o_done      <= 1'b0;
            o_fail_code <= '0;
            o_err_total <= '0;
            o_lane_mask <= '0;
          end
        end

        S_DP_RESET: begin
          if (dp_cnt == DPW'(DP_RST_CYCLES - 1)) begin
            state       <= S_WAIT_SYNC;
            stable_cnt  <= '0;
            timeout_cnt <= '0;
            o_dp_rst    <= 1'b0;
            o_gen_en    <= 1'b1;
            o_chk_en    <= 1'b1;
          end else begin
            dp_cnt <= dp_cnt + DPW'(1);
          end
        end

        S_WAIT_SYNC: begin
          stable_cnt  <= all_sync ? stable_inc : '0;
          timeout_cnt <= timeout_inc;
          // Reaching stability on the timeout cycle still counts as a good link.
          if (all_sync && stable_inc == STW'(SYNC_STABLE)) begin
            state   <= S_RUN;
            run_cnt <= '0;
          end else if (timeout_inc == TOW'(SYNC_TIMEOUT)) begin
            state       <= S_FAIL;
            o_gen_en    <= 1'b0;
            o_chk_en    <= 1'b0;
            o_done      <= 1'b1;
            o_fail_code <= 2'd1;
            o_lane_mask <= ~i_sync_lane;
          end
        end

        S_RUN: begin
          run_cnt     <= run_inc;
          o_err_total <= err_sat;
          if (!all_sync) begin
            state       <= S_FAIL;
            o_gen_en    <= 1'b0;
            o_chk_en    <= 1'b0;
            o_done      <= 1'b1;
            o_fail_code <= 2'd2;
            o_lane_mask <= ~i_sync_lane;
          end else begin
            o_lane_mask <= o_lane_mask | i_lane_err;
            if (run_inc == RNW'(RUN_CYCLES)) begin
              state    <= (err_sat == '0) ? S_PASS : S_FAIL;
              o_gen_en <= 1'b0;
              o_chk_en <= 1'b0;
              o_done   <= 1'b1;
              if (err_sat != '0) o_fail_code <= 2'd3;
            end
          end
        end

        default: begin
          state    <= S_IDLE;
          o_dp_rst <= 1'b1;
          o_gen_en <= 1'b0;
          o_chk_en <= 1'b0;
          o_done   <= 1'b0;
        end
      endcase
    end
  end

endmodule
